// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder for the upper half of the CPU data address space.
// Owns the LED register, synchronized switches, a periodic timer and a TX FIFO.
module mmio_responder #(
  parameter int data_width = 16,
  parameter int fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mem_cmd,
  input  logic [8:0]            mem_addr,
  input  logic [data_width-1:0] din,
  input  logic [7:0]            SW,
  input  logic                  tx_ready,
  output logic [data_width-1:0] rdata,
  output logic                  rhit,
  output logic [7:0]            LEDR,
  output logic [data_width-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  irq
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(fifo_depth);

  localparam logic [1:0] cmd_mwrite = 2'b01;
  localparam logic [1:0] cmd_mread  = 2'b11;

  localparam logic [8:0] addr_led    = 9'h100;
  localparam logic [8:0] addr_sw     = 9'h140;
  localparam logic [8:0] addr_timer  = 9'h180;
  localparam logic [8:0] addr_tstat  = 9'h181;
  localparam logic [8:0] addr_txdata = 9'h1C0;
  localparam logic [8:0] addr_txstat = 9'h1C1;

  // ---------------------------------------------------------------------------
  // Bus decode and single-shot write strobe
  // ---------------------------------------------------------------------------
  logic       is_write;
  logic       is_read;
  logic       prev_write;
  logic [8:0] prev_addr;
  logic       strobe;

  assign is_write = (mem_cmd == cmd_mwrite);
  assign is_read  = (mem_cmd == cmd_mread);

  // A held MWRITE to one address is a single access; only its first cycle acts.
  assign strobe = is_write && !(prev_write && (prev_addr == mem_addr));

  logic wr_led;
  logic wr_timer;
  logic wr_tstat;
  logic wr_txdata;
  logic wr_txstat;

  assign wr_led    = strobe && (mem_addr == addr_led);
  assign wr_timer  = strobe && (mem_addr == addr_timer);
  assign wr_tstat  = strobe && (mem_addr == addr_tstat);
  assign wr_txdata = strobe && (mem_addr == addr_txdata);
  assign wr_txstat = strobe && (mem_addr == addr_txstat);

  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers sample the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_write <= 1'b0;
      prev_addr  <= '0;
    end else begin
      prev_write <= is_write;
      prev_addr  <= mem_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // LED register and switch synchronizer
  // ---------------------------------------------------------------------------
  logic [7:0] led_q;
  logic [7:0] sw_meta;
  logic [7:0] sw_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      if (wr_led) led_q <= din[7:0];
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  assign LEDR = led_q;

  // ---------------------------------------------------------------------------
  // Periodic down-counter timer
  // ---------------------------------------------------------------------------
  logic [15:0] t_count;
  logic [15:0] t_reload;
  logic        t_enabled;
  logic        t_expire;
  logic        expired;

  assign t_enabled = (t_reload != 16'd0);
  // A timer write on the would-be reload edge restarts without expiring.
  assign t_expire  = t_enabled && (t_count == 16'd1) && !wr_timer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_count  <= '0;
      t_reload <= '0;
    end else if (wr_timer) begin
      t_count  <= din[15:0];
      t_reload <= din[15:0];
    end else if (t_expire) begin
      t_count <= t_reload;
    end else if (t_enabled && (t_count != 16'd0)) begin
      t_count <= t_count - 16'd1;
    end
  end

  // Setting the flag outranks a simultaneous software clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expired <= 1'b0;
    end else if (t_expire) begin
      expired <= 1'b1;
    end else if (wr_tstat && din[0]) begin
      expired <= 1'b0;
    end
  end

  assign irq = expired;

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [data_width-1:0] fifo_mem [fifo_depth];
  logic [ptr_w-1:0]      rd_ptr;
  logic [ptr_w-1:0]      wr_ptr;
  logic [cnt_w-1:0]      fifo_cnt;
  logic                  overflow;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == depth_c);
  assign pop        = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = wr_txdata && (!fifo_full || pop);
  assign drop       = wr_txdata && !push;

  // NOTE: the storage array has no reset; entries are only observable through
  // tx_data, which is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (wr_txstat && din[2]) begin
      overflow <= 1'b0;
    end
  end

  assign tx_valid = !fifo_empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : '0;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // NOTE: both outputs get a default before the case so no path through this
  // block leaves them unassigned, which would otherwise infer latches.
  always_comb begin
    rdata = '0;
    rhit  = 1'b0;
    if (is_read) begin
      case (mem_addr)
        addr_led: begin
          rhit       = 1'b1;
          rdata[7:0] = led_q;
        end
        addr_sw: begin
          rhit       = 1'b1;
          rdata[7:0] = sw_sync;
        end
        addr_timer: begin
          rhit        = 1'b1;
          rdata[15:0] = t_count;
        end
        addr_tstat: begin
          rhit     = 1'b1;
          rdata[0] = expired;
        end
        addr_txdata: begin
          rhit = 1'b1;
        end
        addr_txstat: begin
          rhit             = 1'b1;
          rdata[0]         = fifo_empty;
          rdata[1]         = fifo_full;
          rdata[2]         = overflow;
          rdata[3 +: cnt_w] = fifo_cnt;
        end
        default: begin
          rhit = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: per-feature test tasks plus a
// scoreboard queue that checks every word leaving the TX stream.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_cmd = 2'b00;
  logic [8:0]  mem_addr = '0;
  logic [15:0] din = '0;
  logic [7:0]  SW = '0;
  logic        tx_ready = 1'b0;
  logic [15:0] rdata;
  logic        rhit;
  logic [7:0]  LEDR;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        irq;

  int total = 0;
  int bad = 0;

  logic [15:0] sb [$];
  logic [15:0] mon_exp;

  mmio_responder #(
    .data_width (16),
    .fifo_depth (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_cmd  (mem_cmd),
    .mem_addr (mem_addr),
    .din      (din),
    .SW       (SW),
    .tx_ready (tx_ready),
    .rdata    (rdata),
    .rhit     (rhit),
    .LEDR     (LEDR),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Stream monitor: a handshake seen at the negedge pops on the next posedge.
  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got tx_data=%h, required no word (queue empty)", tx_data);
      end else begin
        mon_exp = sb.pop_front();
        if (tx_data !== mon_exp) begin
          bad++;
          $display("FAIL tx_order: got tx_data=%h, required %h", tx_data, mon_exp);
        end
      end
    end
  end

  // Timer timeline: op 0 = read TIMER, 1 = write TSTAT=1, 2 = write TIMER=val.
  int tm_op  [20] = '{2, 0, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 2, 0, 2, 0, 0, 2};
  int tm_val [20] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 5, 0, 0, 0};
  int tm_cnt [20] = '{-1, 3, 2, 1, -1, 2, -1, 3, -1, 1, -1, 0, 0, -1, -1, 2, -1, 5, 4, -1};
  int tm_irq [20] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [15:0] d, input int hold);
    mem_cmd  = 2'b01;
    mem_addr = a;
    din      = d;
    repeat (hold) cyc();
    mem_cmd = 2'b00;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [15:0] d, output logic h);
    mem_cmd  = 2'b11;
    mem_addr = a;
    @(negedge clk);
    d = rdata;
    h = rhit;
    cyc();
    mem_cmd = 2'b00;
  endtask

  task automatic push_word(input logic [15:0] d, input int hold, input bit accept);
    if (accept) sb.push_back(d);
    bus_write(9'h1C0, d, hold);
    cyc();
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) cyc();
    total++;
    if (LEDR !== 8'h00 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: got LEDR=%h irq=%b, required 00 0", LEDR, irq);
    end
    total++;
    if (tx_valid !== 1'b0 || tx_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_fifo: got tx_valid=%b tx_data=%h, required 0 0000", tx_valid, tx_data);
    end
    total++;
    if (rhit !== 1'b0 || rdata !== 16'h0000) begin
      bad++;
      $display("FAIL reset_bus: got rhit=%b rdata=%h, required 0 0000", rhit, rdata);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_led();
    logic [15:0] d;
    logic        h;
    bus_write(9'h100, 16'h00A5, 3);
    cyc();
    total++;
    if (LEDR !== 8'hA5) begin
      bad++;
      $display("FAIL led_write: got LEDR=%h, required a5", LEDR);
    end
    bus_read(9'h100, d, h);
    total++;
    if (d !== 16'h00A5 || h !== 1'b1) begin
      bad++;
      $display("FAIL led_read: got rdata=%h rhit=%b, required 00a5 1", d, h);
    end
    reset = 1'b0;
    #1;
    total++;
    if (LEDR !== 8'h00) begin
      bad++;
      $display("FAIL led_async_reset: got LEDR=%h, required 00", LEDR);
    end
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_switches();
    logic [15:0] d;
    logic        h;
    SW = 8'h3C;
    cyc();
    cyc();
    bus_read(9'h140, d, h);
    total++;
    if (d !== 16'h003C || h !== 1'b1) begin
      bad++;
      $display("FAIL sw_read: got rdata=%h rhit=%b, required 003c 1", d, h);
    end
    SW = 8'h5A;
    cyc();
    bus_read(9'h140, d, h);
    total++;
    if (d !== 16'h003C) begin
      bad++;
      $display("FAIL sw_sync_latency: got rdata=%h after 1 edge, required 003c", d);
    end
    bus_read(9'h140, d, h);
    total++;
    if (d !== 16'h005A) begin
      bad++;
      $display("FAIL sw_sync_arrive: got rdata=%h after 2 edges, required 005a", d);
    end
    bus_read(9'h150, d, h);
    total++;
    if (d !== 16'h0000 || h !== 1'b0) begin
      bad++;
      $display("FAIL unmapped_read: got rdata=%h rhit=%b, required 0000 0", d, h);
    end
  endtask

  task automatic test_timer();
    for (int k = 0; k < 20; k++) begin
      case (tm_op[k])
        0: begin
          mem_cmd  = 2'b11;
          mem_addr = 9'h180;
        end
        1: begin
          mem_cmd  = 2'b01;
          mem_addr = 9'h181;
          din      = 16'h0001;
        end
        default: begin
          mem_cmd  = 2'b01;
          mem_addr = 9'h180;
          din      = 16'(tm_val[k]);
        end
      endcase
      @(negedge clk);
      total++;
      if (irq !== tm_irq[k][0]) begin
        bad++;
        $display("FAIL timer_irq step %0d: got irq=%b, required %0d", k, irq, tm_irq[k]);
      end
      if (tm_cnt[k] >= 0) begin
        total++;
        if (rdata !== 16'(tm_cnt[k]) || rhit !== 1'b1) begin
          bad++;
          $display("FAIL timer_count step %0d: got rdata=%0d rhit=%b, required %0d 1",
                   k, rdata, rhit, tm_cnt[k]);
        end
      end
      cyc();
    end
    mem_cmd = 2'b00;
    cyc();
  endtask

  task automatic test_fifo_overflow();
    logic [15:0] d;
    logic        h;
    tx_ready = 1'b0;
    push_word(16'h1111, 3, 1'b1);
    bus_read(9'h1C1, d, h);
    total++;
    if (d !== 16'h0008) begin
      bad++;
      $display("FAIL txstat_single_push: got %h, required 0008", d);
    end
    push_word(16'h2222, 1, 1'b1);
    push_word(16'h3333, 1, 1'b1);
    push_word(16'h4444, 1, 1'b1);
    bus_read(9'h1C1, d, h);
    total++;
    if (d !== 16'h0022) begin
      bad++;
      $display("FAIL txstat_full: got %h, required 0022", d);
    end
    push_word(16'h5555, 1, 1'b0);
    bus_read(9'h1C1, d, h);
    total++;
    if (d !== 16'h0026 || h !== 1'b1) begin
      bad++;
      $display("FAIL txstat_overflow: got %h rhit=%b, required 0026 1", d, h);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 16'h1111) begin
        bad++;
        $display("FAIL tx_stall_stable: got tx_valid=%b tx_data=%h, required 1 1111", tx_valid, tx_data);
      end
      cyc();
    end
  endtask

  task automatic test_push_pop();
    logic [15:0] d;
    logic        h;
    sb.push_back(16'h6666);
    tx_ready = 1'b1;
    mem_cmd  = 2'b01;
    mem_addr = 9'h1C0;
    din      = 16'h6666;
    cyc();
    tx_ready = 1'b0;
    mem_cmd  = 2'b00;
    cyc();
    bus_read(9'h1C1, d, h);
    total++;
    if (d !== 16'h0026) begin
      bad++;
      $display("FAIL push_pop_full: got TXSTAT=%h, required 0026", d);
    end
    bus_read(9'h1C0, d, h);
    total++;
    if (d !== 16'h0000 || h !== 1'b1) begin
      bad++;
      $display("FAIL txdata_read: got rdata=%h rhit=%b, required 0000 1", d, h);
    end
    bus_write(9'h1C1, 16'h0004, 1);
    cyc();
    bus_read(9'h1C1, d, h);
    total++;
    if (d !== 16'h0022) begin
      bad++;
      $display("FAIL overflow_clear: got TXSTAT=%h, required 0022", d);
    end
  endtask

  task automatic test_drain();
    int  n = 0;
    bit  done = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!tx_valid) done = 1'b1;
      else n++;
      cyc();
    end
    tx_ready = 1'b0;
    total++;
    if (!done || n != 4) begin
      bad++;
      $display("FAIL drain_cycles: got %0d valid cycles (ended=%b), required 4 1", n, done);
    end
    total++;
    if (sb.size() != 0 || tx_data !== 16'h0000) begin
      bad++;
      $display("FAIL drain_empty: got %0d words pending tx_data=%h, required 0 0000", sb.size(), tx_data);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [15:0] d;
    logic        h;
    push_word(16'hC001, 1, 1'b1);
    push_word(16'hC002, 1, 1'b1);
    push_word(16'hC003, 1, 1'b1);
    tx_ready = 1'b1;
    cyc();
    reset = 1'b0;
    sb.delete();
    #1;
    total++;
    if (tx_valid !== 1'b0 || tx_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid_drain: got tx_valid=%b tx_data=%h, required 0 0000", tx_valid, tx_data);
    end
    tx_ready = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    bus_read(9'h1C1, d, h);
    total++;
    if (d !== 16'h0001) begin
      bad++;
      $display("FAIL txstat_after_reset: got %h, required 0001", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_led();
    test_switches();
    test_timer();
    test_fifo_overflow();
    test_push_pop();
    test_drain();
    test_reset_mid_drain();
    repeat (2) cyc();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d words, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the CPU data-memory bus: decodes `mem_cmd`/`mem_addr` for the upper half of the 9-bit address space (`mem_addr[8]=1`), returns read data to the CPU's `mdata` mux, and executes write side effects. It owns the LED register, a synchronized switch input, a periodic down-counter timer, and a transmit FIFO drained by a valid/ready stream. RAM stays responsible for `mem_addr[8]=0`.

## Interface
- `data_width`, 16: bus data width; must be ≥16.
- `fifo_depth`, 4: TX FIFO entries; power of two, ≥2.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `mem_cmd` in 2: `01` = MWRITE, `11` = MREAD, all other values idle.
- `mem_addr` in 9: byte-free word address.
- `din` in data_width: CPU write data (datapath out).
- `SW` in 8: asynchronous switches.
- `tx_ready` in 1: downstream accepts `tx_data` this cycle.
- `rdata` out data_width: read data, combinational.
- `rhit` out 1: 1 when MREAD targets a mapped register; CPU selects `rdata` into `mdata`.
- `LEDR` out 8: LED register.
- `tx_data` out data_width: FIFO head.
- `tx_valid` out 1: FIFO non-empty.
- `irq` out 1: timer expired flag.

## Operation
- Address map; any other address with `mem_addr[8]=1` gives `rhit=0`, `rdata=0`, writes ignored:
  - `0x100` LED: R/W, `[7:0]`.
  - `0x140` SW: R, `{0, sw_sync[7:0]}`; `SW` passes through a 2-flop synchronizer.
  - `0x180` TIMER: read = current count; write loads count and reload value from `din[15:0]`; a write of 0 disables the timer.
  - `0x181` TSTAT: bit0 = expired; writing bit0=1 clears it.
  - `0x1C0` TXDATA: write pushes `din`; reads return 0 with `rhit=1`.
  - `0x1C1` TXSTAT: bit0 empty, bit1 full, bit2 overflow (sticky), bits[3+:clog2(fifo_depth)+1] count; writing bit2=1 clears overflow.
- Write strobe: a register write takes effect exactly once per access, on the first cycle where `mem_cmd==01`. The cycle counts as a first cycle when the previous cycle was not MWRITE to the same address. Holding MWRITE on the same address for N cycles produces one effect.
- Reads have no side effects.
- Timer: when enabled (reload≠0), decrement every cycle. When count==1, next count = reload and expired is set (periodic). The timer runs 16 bits with no wrap below 1.
- FIFO: circular, read/write pointers wrap modulo `fifo_depth`.
  - Pop when `tx_valid && tx_ready`.
  - Push when the strobe hits TXDATA and either (count<fifo_depth) or a pop happens in the same cycle.
  - A push while full with no pop is dropped and sets overflow.
  - A simultaneous push and pop leaves the count unchanged.

## Timing
- Reset values:
  - `LEDR=0`, timer count and reload 0 (disabled), expired 0, overflow 0.
  - FIFO empty, so `tx_valid=0` and `tx_data=0`.
  - Synchronizer 0, `irq=0`, `rhit=0`, `rdata=0`.
- Reset is asserted asynchronously and may land mid-operation; it discards FIFO contents and any in-progress timer count.
- `rdata`/`rhit` are combinational from `mem_cmd`/`mem_addr` and current state, so they are valid in the same cycle.
- Write effects are visible in registers one cycle after the strobe cycle.
- `SW` reaches a 0x140 read 2 cycles after a change.
- Timer: after a write of value R, count reads R in the next cycle and 1 after R−1 further cycles. Expired and `irq` rise on the edge where count reloads, so the period is R cycles.
- Simultaneous events:
  - Expire and TSTAT clear in the same cycle: set wins.
  - Overflow set and clear in the same cycle: set wins.
  - A TIMER write during countdown restarts the timer from the new value, and expired is not set on that edge.
- FIFO: a pushed word appears at `tx_data` with `tx_valid=1` one cycle after the strobe if the FIFO was empty. `tx_data` must stay stable while `tx_valid && !tx_ready`.

## Test plan
- Reset, then write `0x100` with `din=0x00A5` holding MWRITE for 3 cycles; then read `0x100` → `LEDR=0xA5`, `rdata=0x00A5`, `rhit=1`; reassert reset → `LEDR=0`.
- Set `SW=0x3C`, then read `0x140` two cycles later → `rdata=0x003C`. Read `0x150` → `rhit=0`, `rdata=0`.
- Write TIMER=3 → `irq` rises 3 cycles later and again every 3 cycles. Write TSTAT=1 on an expiry edge → `irq` stays 1. Write TIMER=0 → count freezes at 0.
- With `tx_ready=0`, push 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 → TXSTAT full=1, count=4, overflow=1, `tx_data=0x1111` stable. Raise `tx_ready` → words drain in order over 4 cycles and `tx_valid` falls.
- With the FIFO full and `tx_ready=1`, push 0x6666 in the same cycle as a pop → accepted, count stays 4, overflow unchanged; write TXSTAT bit2=1 → overflow clears.
- Assert reset mid-drain with 2 entries queued → `tx_valid=0` immediately (async). After release, TXSTAT reads empty=1, count=0.
